// File: rtl/mbldcm_pkg.sv
// Shared encodings for the BLDC gate driver: phase FSM states, per-phase
// requests and the Hall-code commutation table.
package mbldcm_pkg;

  typedef enum logic [1:0] {
    PH_OFF  = 2'd0,
    PH_DEAD = 2'd1,
    PH_HI   = 2'd2,
    PH_LO   = 2'd3
  } phase_state_e;

  typedef enum logic [1:0] {
    REQ_FLOAT = 2'd0,
    REQ_HI    = 2'd1,
    REQ_LO    = 2'd2
  } phase_req_e;

  localparam logic [2:0] SECTOR_INVALID = 3'd7;

  // Hall codes {C,B,A} for sectors 0..5
  localparam logic [2:0] HALL_S0 = 3'b101;
  localparam logic [2:0] HALL_S1 = 3'b100;
  localparam logic [2:0] HALL_S2 = 3'b110;
  localparam logic [2:0] HALL_S3 = 3'b010;
  localparam logic [2:0] HALL_S4 = 3'b011;
  localparam logic [2:0] HALL_S5 = 3'b001;

  localparam logic [1:0] PHASE_A = 2'd0;
  localparam logic [1:0] PHASE_B = 2'd1;
  localparam logic [1:0] PHASE_C = 2'd2;

  function automatic logic [2:0] hall_to_sector(input logic [2:0] hall);
    case (hall)
      HALL_S0: hall_to_sector = 3'd0;
      HALL_S1: hall_to_sector = 3'd1;
      HALL_S2: hall_to_sector = 3'd2;
      HALL_S3: hall_to_sector = 3'd3;
      HALL_S4: hall_to_sector = 3'd4;
      HALL_S5: hall_to_sector = 3'd5;
      default: hall_to_sector = SECTOR_INVALID;
    endcase
  endfunction

  // Phase carrying PWM in the forward direction
  function automatic logic [1:0] sector_pos(input logic [2:0] sector);
    case (sector)
      3'd0, 3'd1: sector_pos = PHASE_A;
      3'd2, 3'd3: sector_pos = PHASE_B;
      default:    sector_pos = PHASE_C;
    endcase
  endfunction

  // Phase held low in the forward direction
  function automatic logic [1:0] sector_neg(input logic [2:0] sector);
    case (sector)
      3'd0, 3'd5: sector_neg = PHASE_B;
      3'd1, 3'd2: sector_neg = PHASE_C;
      default:    sector_neg = PHASE_A;
    endcase
  endfunction

endpackage

// File: rtl/mbldcm_deadtime_phase.sv
// One inverter leg: OFF/DEAD/HI/LO state machine with dead-time counter and
// registered gate outputs. High and low gates are decoded from a single
// state so they can never be asserted together.
module mbldcm_deadtime_phase
  import mbldcm_pkg::*;
#(
  parameter int pDeadWidth = 8
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iForceOff,
  input  phase_req_e            iReq,
  input  logic [pDeadWidth-1:0] iDeadCnt,
  output logic                  oGateH,
  output logic                  oGateL
);

  phase_state_e          state_q, state_d;
  logic [pDeadWidth-1:0] cnt_q, cnt_d;
  logic                  gate_h_q, gate_h_d;
  logic                  gate_l_q, gate_l_d;
  logic [pDeadWidth-1:0] dead_load;

  assign dead_load = (iDeadCnt == '0) ? pDeadWidth'(1) : iDeadCnt;

  // State, counter and gate registers; reset drops the gates asynchronously
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q  <= PH_OFF;
      cnt_q    <= '0;
      gate_h_q <= 1'b0;
      gate_l_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      gate_h_q <= gate_h_d;
      gate_l_q <= gate_l_d;
    end
  end

  // Next state: the ON target while in DEAD is the live request, so a
  // target change during the count redirects without restarting it
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (iForceOff) begin
      state_d = PH_OFF;
    end else begin
      case (state_q)
        PH_OFF: begin
          if (iReq != REQ_FLOAT) begin
            state_d = PH_DEAD;
            cnt_d   = dead_load;
          end
        end
        PH_DEAD: begin
          if (iReq == REQ_FLOAT) begin
            state_d = PH_OFF;
          end else if (cnt_q <= pDeadWidth'(1)) begin
            state_d = (iReq == REQ_HI) ? PH_HI : PH_LO;
          end else begin
            cnt_d = cnt_q - pDeadWidth'(1);
          end
        end
        PH_HI: begin
          if (iReq == REQ_FLOAT) begin
            state_d = PH_OFF;
          end else if (iReq == REQ_LO) begin
            state_d = PH_DEAD;
            cnt_d   = dead_load;
          end
        end
        PH_LO: begin
          if (iReq == REQ_FLOAT) begin
            state_d = PH_OFF;
          end else if (iReq == REQ_HI) begin
            state_d = PH_DEAD;
            cnt_d   = dead_load;
          end
        end
        default: state_d = PH_OFF;
      endcase
    end
    gate_h_d = (state_d == PH_HI);
    gate_l_d = (state_d == PH_LO);
  end

  assign oGateH = gate_h_q;
  assign oGateL = gate_l_q;

endmodule

// File: rtl/mbldcm_gate_drive.sv
// Six-step BLDC gate driver: Hall synchroniser, commutation decode, fault
// latch and three dead-time phase legs.
// Optional Hall glitch filter enabled with `define MBLDCM_HALL_FILTER_EN.
module mbldcm_gate_drive
  import mbldcm_pkg::*;
#(
  parameter int pDeadWidth = 8,
  parameter int pFiltLen   = 4
) (
  input  logic                  iClock,
  input  logic                  iReset,
  input  logic                  iEnable,
  input  logic                  iDir,
  input  logic                  iHighPwm,
  input  logic                  iLowPwm,
  input  logic [pDeadWidth-1:0] iDeadCnt,
  input  logic [2:0]            iHall,
  input  logic                  iFault,
  input  logic                  iFaultClr,
  output logic [2:0]            oGateH,
  output logic [2:0]            oGateL,
  output logic [2:0]            oSector,
  output logic                  oHallErr,
  output logic                  oFaultLatched,
  output logic                  oPwmErr
);

  // The filter's acceptance point is pFiltLen-1 counts, so it needs at least 2
  if (pFiltLen < 2) begin : g_filt_len_chk
    $error("pFiltLen must be at least 2");
  end

  logic [2:0] hall_s1_q, hall_s1_d;
  logic [2:0] hall_s2_q, hall_s2_d;
  logic [2:0] hall_used;
  logic [2:0] sector_q, sector_d;
  logic       hall_err_q, hall_err_d;
  logic       fault_q, fault_d;
  logic       pwm_err_q, pwm_err_d;
  logic       force_off;
  logic [1:0] pos_ph, neg_ph;
  phase_req_e req [3];
  logic [2:0] gate_h, gate_l;

  // Synchroniser, status and fault-latch registers
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      hall_s1_q  <= 3'b000;
      hall_s2_q  <= 3'b000;
      sector_q   <= SECTOR_INVALID;
      hall_err_q <= 1'b0;
      fault_q    <= 1'b0;
      pwm_err_q  <= 1'b0;
    end else begin
      hall_s1_q  <= hall_s1_d;
      hall_s2_q  <= hall_s2_d;
      sector_q   <= sector_d;
      hall_err_q <= hall_err_d;
      fault_q    <= fault_d;
      pwm_err_q  <= pwm_err_d;
    end
  end

  // Next values: the fault input dominates a simultaneous clear
  always_comb begin
    hall_s1_d  = iHall;
    hall_s2_d  = hall_s1_q;
    sector_d   = hall_to_sector(hall_used);
    hall_err_d = (sector_d == SECTOR_INVALID);
    pwm_err_d  = (iHighPwm == iLowPwm);
    if (iFault) begin
      fault_d = 1'b1;
    end else if (iFaultClr) begin
      fault_d = 1'b0;
    end else begin
      fault_d = fault_q;
    end
  end

`ifdef MBLDCM_HALL_FILTER_EN
  localparam int FCW = $clog2(pFiltLen + 1);

  logic [2:0]     filt_cand_q, filt_cand_d;
  logic [2:0]     filt_acc_q, filt_acc_d;
  logic [FCW-1:0] filt_cnt_q, filt_cnt_d;

  // Filter registers: candidate code, its stability count, accepted code
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      filt_cand_q <= 3'b000;
      filt_acc_q  <= 3'b000;
      filt_cnt_q  <= '0;
    end else begin
      filt_cand_q <= filt_cand_d;
      filt_acc_q  <= filt_acc_d;
      filt_cnt_q  <= filt_cnt_d;
    end
  end

  // A code is used in the cycle it completes pFiltLen stable samples
  always_comb begin
    filt_cand_d = hall_s2_q;
    filt_cnt_d  = filt_cnt_q;
    if (hall_s2_q != filt_cand_q) begin
      filt_cnt_d = FCW'(1);
    end else if (filt_cnt_q != FCW'(pFiltLen)) begin
      filt_cnt_d = filt_cnt_q + FCW'(1);
    end
    if ((hall_s2_q == filt_cand_q) && (filt_cnt_q >= FCW'(pFiltLen - 1))) begin
      hall_used = hall_s2_q;
    end else begin
      hall_used = filt_acc_q;
    end
    filt_acc_d = hall_used;
  end
`else
  assign hall_used = hall_s2_q;
`endif

  assign force_off = iFault | fault_q;

  // Commutation decode into per-phase requests; float everything when idle
  always_comb begin
    for (int n = 0; n < 3; n++) begin
      req[n] = REQ_FLOAT;
    end
    pos_ph = sector_pos(sector_d);
    neg_ph = sector_neg(sector_d);
    if (iDir) begin
      pos_ph = sector_neg(sector_d);
      neg_ph = sector_pos(sector_d);
    end
    if (iEnable && !fault_q && (sector_d != SECTOR_INVALID)) begin
      req[pos_ph] = iHighPwm ? REQ_HI : REQ_LO;
      req[neg_ph] = REQ_LO;
    end
  end

  for (genvar n = 0; n < 3; n++) begin : g_phase
    mbldcm_deadtime_phase #(
      .pDeadWidth(pDeadWidth)
    ) u_phase (
      .iClock   (iClock),
      .iReset   (iReset),
      .iForceOff(force_off),
      .iReq     (req[n]),
      .iDeadCnt (iDeadCnt),
      .oGateH   (gate_h[n]),
      .oGateL   (gate_l[n])
    );
  end

  assign oGateH        = gate_h;
  assign oGateL        = gate_l;
  assign oSector       = sector_q;
  assign oHallErr      = hall_err_q;
  assign oFaultLatched = fault_q;
  assign oPwmErr       = pwm_err_q;

endmodule

// File: tb/tb_mbldcm_gate_drive.sv
// Directed bench for mbldcm_gate_drive; Hall latency adapts to
// MBLDCM_HALL_FILTER_EN.
module tb_mbldcm_gate_drive;

`ifdef MBLDCM_HALL_FILTER_EN
  localparam int HL = 6;
`else
  localparam int HL = 3;
`endif

  logic       iClock = 1'b0;
  logic       iReset;
  logic       iEnable;
  logic       iDir;
  logic       iHighPwm;
  logic       iLowPwm;
  logic [7:0] iDeadCnt;
  logic [2:0] iHall;
  logic       iFault;
  logic       iFaultClr;
  logic [2:0] oGateH;
  logic [2:0] oGateL;
  logic [2:0] oSector;
  logic       oHallErr;
  logic       oFaultLatched;
  logic       oPwmErr;

  int checks = 0;
  int errors = 0;

  mbldcm_gate_drive #(.pDeadWidth(8), .pFiltLen(4)) dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .iEnable      (iEnable),
    .iDir         (iDir),
    .iHighPwm     (iHighPwm),
    .iLowPwm      (iLowPwm),
    .iDeadCnt     (iDeadCnt),
    .iHall        (iHall),
    .iFault       (iFault),
    .iFaultClr    (iFaultClr),
    .oGateH       (oGateH),
    .oGateL       (oGateL),
    .oSector      (oSector),
    .oHallErr     (oHallErr),
    .oFaultLatched(oFaultLatched),
    .oPwmErr      (oPwmErr)
  );

  always #5 iClock = ~iClock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge iClock);
    #1;
  endtask

  task automatic pwm(input logic hi);
    iHighPwm = hi;
    iLowPwm  = ~hi;
  endtask

  // Shoot-through guard on every falling edge
  always @(negedge iClock) begin
    if (iReset === 1'b0) begin
      checks++;
      assert ((oGateH & oGateL) === 3'b000) else begin
        errors++;
        $error("FAIL shoot_through observed H=%b L=%b expected no overlap", oGateH, oGateL);
      end
    end
  end

  initial begin
    iReset = 1'b1; iEnable = 1'b0; iDir = 1'b0; pwm(1'b0);
    iDeadCnt = 8'd5; iHall = 3'b101; iFault = 1'b0; iFaultClr = 1'b0;

    // reset values
    step(1);
    chk("rst_gateh", {5'd0, oGateH}, 8'h00);
    chk("rst_gatel", {5'd0, oGateL}, 8'h00);
    chk("rst_sector", {5'd0, oSector}, 8'h07);
    chk("rst_hallerr", {7'd0, oHallErr}, 8'h00);
    chk("rst_fault", {7'd0, oFaultLatched}, 8'h00);
    chk("rst_pwmerr", {7'd0, oPwmErr}, 8'h00);
    iReset = 1'b0;
    step(HL + 1);
    chk("dis_sector", {5'd0, oSector}, 8'h00);
    chk("dis_gates", {2'd0, oGateH, oGateL}, 8'h00);

    // sector 0 forward, dead 5: A PWM, B low
    iEnable = 1'b1; pwm(1'b1);
    step(5);
    chk("t1_dead_gates", {2'd0, oGateH, oGateL}, 8'h00);
    step(1);
    chk("t1_on_h", {5'd0, oGateH}, 8'h01);
    chk("t1_on_l", {5'd0, oGateL}, 8'h02);
    pwm(1'b0);
    step(1);
    chk("t1_fall_h", {5'd0, oGateH}, 8'h00);
    chk("t1_fall_l", {5'd0, oGateL}, 8'h02);
    step(4);
    chk("t1_fall_l5", {5'd0, oGateL}, 8'h02);
    step(1);
    chk("t1_fall_l6", {5'd0, oGateL}, 8'h03);
    pwm(1'b1);
    step(1);
    chk("t1_rise_l", {5'd0, oGateL}, 8'h02);
    step(4);
    chk("t1_rise_h5", {5'd0, oGateH}, 8'h00);
    step(1);
    chk("t1_rise_h6", {5'd0, oGateH}, 8'h01);
    iLowPwm = 1'b1;
    step(1);
    chk("pwmerr_set", {7'd0, oPwmErr}, 8'h01);
    iLowPwm = 1'b0;
    step(1);
    chk("pwmerr_clr", {7'd0, oPwmErr}, 8'h00);

    // dead count 0 behaves as 1
    iDeadCnt = 8'd0; pwm(1'b0);
    step(1);
    chk("t2_gap_a", {2'd0, oGateH, oGateL}, 8'h02);
    step(1);
    chk("t2_lo_a", {2'd0, oGateH, oGateL}, 8'h03);
    pwm(1'b1);
    step(1);
    chk("t2_gap_b", {2'd0, oGateH, oGateL}, 8'h02);
    step(1);
    chk("t2_hi_a", {2'd0, oGateH, oGateL}, 8'h0A);

    // sector 0 -> 1: B low drops, C low after dead 3
    iDeadCnt = 8'd3; iHall = 3'b100;
    step(HL - 1);
    chk("t3_pre_sector", {5'd0, oSector}, 8'h00);
    chk("t3_pre_l", {5'd0, oGateL}, 8'h02);
    step(1);
    chk("t3_sector", {5'd0, oSector}, 8'h01);
    chk("t3_gates", {2'd0, oGateH, oGateL}, 8'h08);
    step(2);
    chk("t3_dead_l", {5'd0, oGateL}, 8'h00);
    step(1);
    chk("t3_c_low", {2'd0, oGateH, oGateL}, 8'h0C);

    // reverse direction swaps roles: C PWM, A low
    iDir = 1'b1;
    step(1);
    chk("dir_dead", {2'd0, oGateH, oGateL}, 8'h00);
    step(3);
    chk("dir_rev", {2'd0, oGateH, oGateL}, 8'h21);
    iDir = 1'b0;
    step(4);
    chk("dir_fwd", {2'd0, oGateH, oGateL}, 8'h0C);

    // invalid Hall code
    iHall = 3'b000;
    step(HL);
    chk("t4_sector", {5'd0, oSector}, 8'h07);
    chk("t4_hallerr", {7'd0, oHallErr}, 8'h01);
    chk("t4_gates", {2'd0, oGateH, oGateL}, 8'h00);
    iHall = 3'b100;
    step(HL);
    chk("t4_back_sector", {5'd0, oSector}, 8'h01);
    chk("t4_back_err", {7'd0, oHallErr}, 8'h00);
    step(3);
    chk("t4_back_gates", {2'd0, oGateH, oGateL}, 8'h0C);

    // fault latch
    iFault = 1'b1;
    step(1);
    chk("t5_gates", {2'd0, oGateH, oGateL}, 8'h00);
    chk("t5_latched", {7'd0, oFaultLatched}, 8'h01);
    iFaultClr = 1'b1;
    step(1);
    chk("t5_clr_blocked", {7'd0, oFaultLatched}, 8'h01);
    iFaultClr = 1'b0; iFault = 1'b0;
    step(1);
    chk("t5_sticky", {7'd0, oFaultLatched}, 8'h01);
    chk("t5_sticky_gates", {2'd0, oGateH, oGateL}, 8'h00);
    iFaultClr = 1'b1;
    step(1);
    chk("t5_cleared", {7'd0, oFaultLatched}, 8'h00);
    iFaultClr = 1'b0;
    step(3);
    chk("t5_resume_dead", {2'd0, oGateH, oGateL}, 8'h00);
    step(1);
    chk("t5_resume_on", {2'd0, oGateH, oGateL}, 8'h0C);

    // asynchronous reset mid-operation
    @(posedge iClock);
    #3 iReset = 1'b1;
    #1;
    chk("async_rst_gates", {2'd0, oGateH, oGateL}, 8'h00);
    chk("async_rst_sector", {5'd0, oSector}, 8'h07);
    step(1);
    iReset = 1'b0;
    step(HL + 1);
    chk("post_rst_sector", {5'd0, oSector}, 8'h01);

`ifdef MBLDCM_HALL_FILTER_EN
    // 3-cycle glitch rejected, 4-cycle change accepted
    iHall = 3'b110;
    step(3);
    iHall = 3'b100;
    step(HL + 3);
    chk("f_glitch_sector", {5'd0, oSector}, 8'h01);
    chk("f_glitch_gates", {2'd0, oGateH, oGateL}, 8'h0C);
    iHall = 3'b110;
    step(4);
    iHall = 3'b100;
    step(1);
    chk("f_accept_pre", {5'd0, oSector}, 8'h01);
    step(1);
    chk("f_accept", {5'd0, oSector}, 8'h02);
    step(HL + 2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
